rf16x160_wr_ctrl: RTL and testbench

Write-side controller for the 16-entry `bw_r_rf16x160` register-file slice. It time-shares the array's single write port between two requesters with round-robin arbitration. It enforces per-entry lock bits that only reset can clear, and runs a sequential clear that zeroes every unlocked entry. It sits between the requesters and the array's `wen`/`word_wen`/`wr_addr`/`wr_data` inputs.

---
 rtl/rf16x160_wr_ctrl_pkg.sv | 16 +
 rtl/rf16x160_wr_ctrl_rr_arb2.sv | 42 ++++
 rtl/rf16x160_wr_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rf16x160_wr_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf16x160_wr_ctrl_pkg.sv
// rf16_ctrl_pkg: shared sizes, state/requester encodings and the array
// word-enable pattern for the rf16x160 write controller.
// No ports; imported by rr_arb2 and rf16x160_wr_ctrl.
package rf16_ctrl_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;

  // Only word 3 of the array is written; it holds data bits [7] and [3].
  localparam logic [3:0] WORD_WEN_ON = 4'b1000;

  typedef enum logic {ST_IDLE, ST_CLEAR} ctrl_state_t;
  typedef enum logic {REQ_A, REQ_B} req_id_t;

endpackage

// File: rtl/rf16x160_wr_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   valid_i[1:0] request lines, bit 0 = A, bit 1 = B
//   advance_i    a grant was taken this cycle; move the pointer to the winner
//   grant_o[1:0] one-hot grant, combinational from valid_i and the pointer
module rr_arb2
  import rf16_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  req_id_t last_q, last_d;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == REQ_A) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance_i && (grant_o != 2'b00))
      last_d = grant_o[1] ? REQ_B : REQ_A;
  end

  // Pointer starts at B so that A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= REQ_B;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/rf16x160_wr_ctrl.sv
// rf16x160_wr_ctrl: write-side controller for the 16-entry bw_r_rf16x160
// slice. Shares the single array write port between requesters A and B,
// holds sticky per-entry lock bits and runs a clear sweep over unlocked entries.
// Ports:
//   clk, reset_r                    clock, asynchronous active-high reset
//   req_{a,b}_valid/addr/data/ready write requests, accepted on valid & ready
//   lock_valid, lock_addr           set one lock bit (cleared only by reset)
//   clr_req, clr_busy, clr_done     sweep start, sweep active, end-of-sweep pulse
//   wr_err, wr_err_id               pulse when an accepted write hit a locked entry
//   lock_status                     current lock bits
//   rf_wen/word_wen/wr_addr/wr_data array write port, registered
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate A/B, one accepted write per cycle
// ST_CLEAR | check entry cnt_q each cycle, zero it next cycle if unlocked
module rf16x160_wr_ctrl
  import rf16_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_r,
  input  logic                   req_a_valid,
  output logic                   req_a_ready,
  input  logic [ADDR_W-1:0]      req_a_addr,
  input  logic [DATA_W-1:0]      req_a_data,
  input  logic                   req_b_valid,
  output logic                   req_b_ready,
  input  logic [ADDR_W-1:0]      req_b_addr,
  input  logic [DATA_W-1:0]      req_b_data,
  input  logic                   lock_valid,
  input  logic [ADDR_W-1:0]      lock_addr,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic                   wr_err,
  output logic                   wr_err_id,
  output logic [NUM_ENTRIES-1:0] lock_status,
  output logic                   rf_wen,
  output logic [3:0]             rf_word_wen,
  output logic [ADDR_W-1:0]      rf_wr_addr,
  output logic [DATA_W-1:0]      rf_wr_data
);

  ctrl_state_t            state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic [NUM_ENTRIES-1:0] lock_q, lock_d;
  logic                   wen_q, wen_d;
  logic [3:0]             word_wen_q, word_wen_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   err_q, err_d;
  logic                   err_id_q, err_id_d;
  logic                   done_q, done_d;

  logic [1:0]        arb_valid;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Requests are only visible to the arbiter in IDLE, so ready is never
  // high during a sweep.
  assign arb_valid = {req_b_valid, req_a_valid} & {2{state_q == ST_IDLE}};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (reset_r),
    .valid_i   (arb_valid),
    .advance_i (|grant),
    .grant_o   (grant)
  );

  assign req_a_ready = grant[0];
  assign req_b_ready = grant[1];
  assign sel_addr    = grant[1] ? req_b_addr : req_a_addr;
  assign sel_data    = grant[1] ? req_b_data : req_a_data;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lock_d   = lock_q;
    wen_d    = 1'b0;
    addr_d   = '0;
    data_d   = '0;
    err_d    = 1'b0;
    err_id_d = err_id_q;
    done_d   = 1'b0;

    // Lock checks below read lock_q, so a lock landing this cycle does not
    // block a write or clear of the same entry in the same cycle.
    if (lock_valid) lock_d[lock_addr] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          if (lock_q[sel_addr]) begin
            err_d    = 1'b1;
            err_id_d = grant[1];
          end else begin
            wen_d  = 1'b1;
            addr_d = sel_addr;
            data_d = sel_data;
          end
        end
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (!lock_q[cnt_q]) begin
          wen_d  = 1'b1;
          addr_d = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
        // clr_done lands in the same cycle as the write for the last entry.
        if (cnt_q == ADDR_W'(NUM_ENTRIES - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    word_wen_d = wen_d ? WORD_WEN_ON : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset_r) begin
    if (reset_r) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lock_q     <= '0;
      wen_q      <= 1'b0;
      word_wen_q <= 4'b0000;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_id_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      wen_q      <= wen_d;
      word_wen_q <= word_wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
      done_q     <= done_d;
    end
  end

  assign clr_busy    = (state_q == ST_CLEAR);
  assign clr_done    = done_q;
  assign wr_err      = err_q;
  assign wr_err_id   = err_id_q;
  assign lock_status = lock_q;
  assign rf_wen      = wen_q;
  assign rf_word_wen = word_wen_q;
  assign rf_wr_addr  = addr_q;
  assign rf_wr_data  = data_q;

endmodule

// File: tb/tb_rf16x160_wr_ctrl.sv
module tb_rf16x160_wr_ctrl;
  import rf16_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset_r = 1'b1;
  logic                   req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic                   req_a_ready, req_b_ready;
  logic [ADDR_W-1:0]      req_a_addr = '0, req_b_addr = '0;
  logic [DATA_W-1:0]      req_a_data = '0, req_b_data = '0;
  logic                   lock_valid = 1'b0;
  logic [ADDR_W-1:0]      lock_addr = '0;
  logic                   clr_req = 1'b0;
  logic                   clr_busy, clr_done, wr_err, wr_err_id;
  logic [NUM_ENTRIES-1:0] lock_status;
  logic                   rf_wen;
  logic [3:0]             rf_word_wen;
  logic [ADDR_W-1:0]      rf_wr_addr;
  logic [DATA_W-1:0]      rf_wr_data;

  rf16x160_wr_ctrl dut (
    .clk(clk), .reset_r(reset_r),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready),
    .req_a_addr(req_a_addr), .req_a_data(req_a_data),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready),
    .req_b_addr(req_b_addr), .req_b_data(req_b_data),
    .lock_valid(lock_valid), .lock_addr(lock_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .wr_err(wr_err), .wr_err_id(wr_err_id), .lock_status(lock_status),
    .rf_wen(rf_wen), .rf_word_wen(rf_word_wen),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: lock bits, last winner (1 = B) and expected array contents.
  bit          m_lock [NUM_ENTRIES];
  bit          m_last;
  logic [7:0]  m_mem  [NUM_ENTRIES];

  // Mirror of the array, written the way the real array samples its port.
  logic [7:0]  arr [NUM_ENTRIES];
  always @(posedge clk) if (rf_wen) arr[rf_wr_addr] <= rf_wr_data;

  function automatic logic [15:0] lock_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_lock[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_lock[i] = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic test_reset();
    reset_r = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rf_wen, rf_word_wen, rf_wr_addr, rf_wr_data, wr_err, wr_err_id,
         clr_busy, clr_done, lock_status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wen=%b wwen=%b addr=%h data=%h err=%b id=%b busy=%b done=%b lock=%h, expected all 0",
               rf_wen, rf_word_wen, rf_wr_addr, rf_wr_data, wr_err, wr_err_id, clr_busy, clr_done, lock_status);
    end
    reset_r = 1'b0;
    model_reset();
  endtask

  task automatic test_single_write();
    @(negedge clk);
    req_a_valid = 1'b1; req_a_addr = 4'd3; req_a_data = 8'h88;
    #1;
    checks++;
    if (req_a_ready !== 1'b1 || req_b_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: a=%b b=%b, expected a=1 b=0", req_a_ready, req_b_ready);
    end
    m_last = 1'b0; m_mem[3] = 8'h88;
    @(negedge clk);
    req_a_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b1 || rf_word_wen !== 4'b1000 || rf_wr_addr !== 4'd3 ||
        rf_wr_data !== 8'h88 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL single_write: wen=%b wwen=%b addr=%h data=%h err=%b, expected 1 1000 3 88 0",
               rf_wen, rf_word_wen, rf_wr_addr, rf_wr_data, wr_err);
    end
  endtask

  task automatic test_prefill();
    logic [7:0] d [16];
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      if (n > 0) begin
        checks++;
        if (rf_wen !== 1'b1 || rf_wr_addr !== 4'(n - 1) || rf_wr_data !== d[n-1]) begin
          errors++;
          $display("FAIL prefill_write %0d: wen=%b addr=%h data=%h, expected 1 %h %h",
                   n - 1, rf_wen, rf_wr_addr, rf_wr_data, 4'(n - 1), d[n-1]);
        end
      end
      if (n < 16) begin
        d[n] = 8'($urandom);
        req_a_valid = 1'b1; req_a_addr = 4'(n); req_a_data = d[n];
        m_mem[n] = d[n]; m_last = 1'b0;
      end else req_a_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] da, db, e_data;
    logic [3:0] e_addr;
    bit w;
    da = 8'($urandom); db = 8'($urandom);
    e_addr = '0; e_data = '0;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (rf_wen !== 1'b1 || rf_wr_addr !== e_addr || rf_wr_data !== e_data) begin
          errors++;
          $display("FAIL b2b_write %0d: wen=%b addr=%h data=%h, expected 1 %h %h",
                   c, rf_wen, rf_wr_addr, rf_wr_data, e_addr, e_data);
        end
      end
      if (c == 4) begin
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        break;
      end
      req_a_valid = 1'b1; req_a_addr = 4'd1; req_a_data = da;
      req_b_valid = 1'b1; req_b_addr = 4'd2; req_b_data = db;
      #1;
      w = !m_last;
      checks++;
      if (req_a_ready !== !w || req_b_ready !== w) begin
        errors++;
        $display("FAIL b2b_grant %0d: a=%b b=%b, expected a=%b b=%b", c, req_a_ready, req_b_ready, !w, w);
      end
      e_addr = w ? 4'd2 : 4'd1;
      e_data = w ? db : da;
      m_mem[e_addr] = e_data;
      m_last = w;
      if (w) db = 8'($urandom); else da = 8'($urandom);
    end
  endtask

  task automatic test_lock_error();
    logic [7:0] d;
    @(negedge clk);
    lock_valid = 1'b1; lock_addr = 4'd5;
    @(negedge clk);
    lock_valid = 1'b0; m_lock[5] = 1'b1;
    checks++;
    if (lock_status !== lock_vec()) begin
      errors++;
      $display("FAIL lock_set: lock=%h, expected %h", lock_status, lock_vec());
    end
    req_b_valid = 1'b1; req_b_addr = 4'd5; req_b_data = 8'($urandom);
    #1;
    checks++;
    if (req_b_ready !== 1'b1 || req_a_ready !== 1'b0) begin
      errors++;
      $display("FAIL lock_ready_b: a=%b b=%b, expected a=0 b=1", req_a_ready, req_b_ready);
    end
    m_last = 1'b1;
    @(negedge clk);
    req_b_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b0 || wr_err !== 1'b1 || wr_err_id !== 1'b1) begin
      errors++;
      $display("FAIL lock_err_b: wen=%b err=%b id=%b, expected 0 1 1", rf_wen, wr_err, wr_err_id);
    end
    d = 8'($urandom);
    req_a_valid = 1'b1; req_a_addr = 4'd6; req_a_data = d;
    m_last = 1'b0; m_mem[6] = d;
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b1 || rf_wr_addr !== 4'd6 || rf_wr_data !== d || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL lock_write6: wen=%b addr=%h data=%h err=%b, expected 1 6 %h 0",
               rf_wen, rf_wr_addr, rf_wr_data, wr_err, d);
    end
    req_a_addr = 4'd5; req_a_data = 8'($urandom);
    @(negedge clk);
    req_a_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b0 || wr_err !== 1'b1 || wr_err_id !== 1'b0) begin
      errors++;
      $display("FAIL lock_err_a: wen=%b err=%b id=%b, expected 0 1 0", rf_wen, wr_err, wr_err_id);
    end
  endtask

  task automatic test_random_traffic(input int ncyc);
    bit pa, pb, has, w, lv, e_wen, e_err, e_id;
    logic [3:0] aa, ab, la, e_addr;
    logic [7:0] da, db, e_data;
    pa = 0; pb = 0; e_wen = 0; e_err = 0; e_id = 0;
    aa = '0; ab = '0; da = '0; db = '0; e_addr = '0; e_data = '0;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      checks++;
      if (rf_wen !== e_wen || wr_err !== e_err ||
          (e_wen && (rf_wr_addr !== e_addr || rf_wr_data !== e_data || rf_word_wen !== 4'b1000)) ||
          (!e_wen && rf_word_wen !== 4'b0000) || (e_err && wr_err_id !== e_id)) begin
        errors++;
        $display("FAIL traffic_out %0d: wen=%b addr=%h data=%h err=%b id=%b, expected wen=%b addr=%h data=%h err=%b id=%b",
                 c, rf_wen, rf_wr_addr, rf_wr_data, wr_err, wr_err_id, e_wen, e_addr, e_data, e_err, e_id);
      end
      checks++;
      if (lock_status !== lock_vec()) begin
        errors++;
        $display("FAIL traffic_lock %0d: lock=%h, expected %h", c, lock_status, lock_vec());
      end
      if (c == ncyc) break;
      if (!pa && $urandom_range(0, 1) == 1) begin pa = 1; aa = 4'($urandom); da = 8'($urandom); end
      if (!pb && $urandom_range(0, 1) == 1) begin pb = 1; ab = 4'($urandom); db = 8'($urandom); end
      lv = ($urandom_range(0, 7) == 0);
      la = 4'($urandom_range(10, 13));
      req_a_valid = pa; req_a_addr = aa; req_a_data = da;
      req_b_valid = pb; req_b_addr = ab; req_b_data = db;
      lock_valid = lv; lock_addr = la;
      #1;
      has = pa | pb;
      w = (pa && pb) ? !m_last : pb;
      checks++;
      if (req_a_ready !== (has && !w) || req_b_ready !== (has && w)) begin
        errors++;
        $display("FAIL traffic_grant %0d: a=%b b=%b, expected a=%b b=%b",
                 c, req_a_ready, req_b_ready, has && !w, has && w);
      end
      e_wen = 0; e_err = 0;
      if (has) begin
        e_addr = w ? ab : aa;
        e_data = w ? db : da;
        if (m_lock[e_addr]) begin e_err = 1; e_id = w; end
        else begin e_wen = 1; m_mem[e_addr] = e_data; end
        m_last = w;
        if (w) pb = 0; else pa = 0;
      end
      if (lv) m_lock[la] = 1'b1;
    end
    req_a_valid = 1'b0; req_b_valid = 1'b0; lock_valid = 1'b0;
  endtask

  task automatic test_clear_sweep(input bit pre_lock, input bit race_en, input logic [3:0] race_addr);
    bit wexp [16];
    bit e_wen, e_busy, e_done;
    if (pre_lock) begin
      @(negedge clk); lock_valid = 1'b1; lock_addr = 4'd0;  m_lock[0]  = 1'b1;
      @(negedge clk); lock_valid = 1'b1; lock_addr = 4'd15; m_lock[15] = 1'b1;
    end
    @(negedge clk);
    lock_valid = 1'b0;
    clr_req = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      clr_req = (k == 5);
      lock_valid = 1'b0;
      e_busy = (k <= 16);
      e_done = (k == 17);
      e_wen  = (k >= 2 && k <= 17) ? wexp[k-2] : 1'b0;
      checks++;
      if (clr_busy !== e_busy || clr_done !== e_done || rf_wen !== e_wen ||
          rf_word_wen !== (e_wen ? 4'b1000 : 4'b0000) ||
          (e_wen && (rf_wr_addr !== 4'(k - 2) || rf_wr_data !== 8'h00))) begin
        errors++;
        $display("FAIL clear_cycle %0d: busy=%b done=%b wen=%b addr=%h data=%h, expected busy=%b done=%b wen=%b addr=%h data=00",
                 k, clr_busy, clr_done, rf_wen, rf_wr_addr, rf_wr_data, e_busy, e_done, e_wen, 4'(k - 2));
      end
      req_a_valid = (k <= 16); req_b_valid = (k <= 16);
      if (k <= 16) begin
        #1;
        checks++;
        if (req_a_ready !== 1'b0 || req_b_ready !== 1'b0) begin
          errors++;
          $display("FAIL clear_ready %0d: a=%b b=%b, expected 0 0", k, req_a_ready, req_b_ready);
        end
        wexp[k-1] = !m_lock[k-1];
        if (wexp[k-1]) m_mem[k-1] = 8'h00;
        if (race_en && 4'(k - 1) == race_addr) begin
          lock_valid = 1'b1; lock_addr = race_addr; m_lock[race_addr] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (arr[i] !== m_mem[i]) begin
        errors++;
        $display("FAIL clear_array[%0d]: got %h, expected %h", i, arr[i], m_mem[i]);
      end
    end
    checks++;
    if (lock_status !== lock_vec()) begin
      errors++;
      $display("FAIL clear_lock: lock=%h, expected %h", lock_status, lock_vec());
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [7:0] d1, d2;
    bit ew;
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      if (n > 0) begin
        ew = !m_lock[n-1];
        checks++;
        if (rf_wen !== ew || wr_err !== !ew) begin
          errors++;
          $display("FAIL refill %0d: wen=%b err=%b, expected wen=%b err=%b", n - 1, rf_wen, wr_err, ew, !ew);
        end
      end
      if (n < 16) begin
        req_b_valid = 1'b1; req_b_addr = 4'(n); req_b_data = 8'h40 + 8'(n);
        if (!m_lock[n]) m_mem[n] = 8'h40 + 8'(n);
        m_last = 1'b1;
      end else req_b_valid = 1'b0;
    end
    clr_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      clr_req = 1'b0;
    end
    // Counter is at 8 in this cycle; writes for entries 0..6 have reached the array.
    @(negedge clk);
    reset_r = 1'b1;
    for (int n = 0; n <= 6; n++) if (!m_lock[n]) m_mem[n] = 8'h00;
    #1;
    checks++;
    if ({rf_wen, rf_word_wen, rf_wr_addr, rf_wr_data, wr_err, wr_err_id,
         clr_busy, clr_done, lock_status} !== '0) begin
      errors++;
      $display("FAIL midsweep_reset: wen=%b addr=%h err=%b busy=%b done=%b lock=%h, expected all 0",
               rf_wen, rf_wr_addr, wr_err, clr_busy, clr_done, lock_status);
    end
    @(negedge clk);
    checks++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_hold: done=%b busy=%b, expected 0 0", clr_done, clr_busy);
    end
    reset_r = 1'b0;
    model_reset();
    d1 = 8'($urandom); d2 = 8'($urandom);
    req_a_valid = 1'b1; req_a_addr = 4'd9;  req_a_data = d1;
    req_b_valid = 1'b1; req_b_addr = 4'd14; req_b_data = d2;
    #1;
    checks++;
    if (req_a_ready !== 1'b1 || req_b_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tie: a=%b b=%b, expected a=1 b=0", req_a_ready, req_b_ready);
    end
    m_last = 1'b0; m_mem[9] = d1;
    @(negedge clk);
    req_a_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b1 || rf_wr_addr !== 4'd9 || rf_wr_data !== d1 || clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_write_a: wen=%b addr=%h data=%h done=%b busy=%b, expected 1 9 %h 0 0",
               rf_wen, rf_wr_addr, rf_wr_data, clr_done, clr_busy, d1);
    end
    m_last = 1'b1; m_mem[14] = d2;
    @(negedge clk);
    req_b_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b1 || rf_wr_addr !== 4'd14 || rf_wr_data !== d2) begin
      errors++;
      $display("FAIL post_reset_write_b: wen=%b addr=%h data=%h, expected 1 e %h", rf_wen, rf_wr_addr, rf_wr_data, d2);
    end
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: wen=%b done=%b, expected 0 0", rf_wen, clr_done);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (arr[i] !== m_mem[i]) begin
        errors++;
        $display("FAIL midsweep_array[%0d]: got %h, expected %h", i, arr[i], m_mem[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_write();
    test_prefill();
    test_back_to_back();
    test_lock_error();
    test_random_traffic(120);
    test_clear_sweep(1'b1, 1'b0, 4'd0);
    test_clear_sweep(1'b0, 1'b1, 4'd7);
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
